// File: rtl/io_pkg.sv
// Shared constants for the W_IO pad conditioning stage: default depths,
// legal parameter ranges and the filter counter width.
package io_pkg;

  localparam int IO_SYNC_STAGES_DEF = 2;
  localparam int IO_FILTER_LEN_DEF  = 4;

  localparam int IO_SYNC_STAGES_MIN = 2;
  localparam int IO_SYNC_STAGES_MAX = 4;
  localparam int IO_FILTER_LEN_MIN  = 1;
  localparam int IO_FILTER_LEN_MAX  = 16;

  // One spare bit above clog2 so FILTER_LEN=1 still yields a 1-bit counter.
  function automatic int io_cnt_width(input int len);
    return $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/io_glitch_filter.sv
// Stability filter: q takes the value of d only after d has differed from q
// for FILTER_LEN consecutive cycles; rise/fall strobe with the change of q.
module io_glitch_filter
  import io_pkg::*;
#(
  parameter int FILTER_LEN = IO_FILTER_LEN_DEF
) (
  input  logic UserCLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  localparam int             CW       = io_cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          o_q, o_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any sample that matches the current output restarts qualification, so a
  // short excursion never accumulates and the counter stops at CNT_LAST.
  always_comb begin
    cnt_d  = cnt_q;
    o_d    = o_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (d == o_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      o_d    = d;
      cnt_d  = '0;
      rise_d = d;
      fall_d = ~d;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      cnt_q  <= '0;
      o_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      o_q    <= o_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = o_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/io_1_bidirectional_sync_filter.sv
// Pad-side conditioning for a bidirectional IO: synchronises and filters the
// pad input, and optionally registers the fabric drive toward the pad.
module io_1_bidirectional_sync_filter
  import io_pkg::*;
#(
  parameter int SYNC_STAGES = IO_SYNC_STAGES_DEF,
  parameter int FILTER_LEN  = IO_FILTER_LEN_DEF,
  parameter bit OUT_REG     = 1'b1
) (
  input  logic UserCLK,
  input  logic RST,
  input  logic I,
  input  logic T,
  input  logic O_top,
  output logic I_top,
  output logic T_top,
  output logic O,
  output logic Q,
  output logic RISE,
  output logic FALL
);

  if (SYNC_STAGES < IO_SYNC_STAGES_MIN || SYNC_STAGES > IO_SYNC_STAGES_MAX) begin : g_bad_sync
    $error("io_1_bidirectional_sync_filter: SYNC_STAGES out of range");
  end
  if (FILTER_LEN < IO_FILTER_LEN_MIN || FILTER_LEN > IO_FILTER_LEN_MAX) begin : g_bad_filter
    $error("io_1_bidirectional_sync_filter: FILTER_LEN out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], O_top};
  end

  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign Q = sync_q[SYNC_STAGES-1];

  io_glitch_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .UserCLK(UserCLK),
    .RST    (RST),
    .d      (Q),
    .q      (O),
    .rise   (RISE),
    .fall   (FALL)
  );

  // T_top is output-enable, so a reset value of 0 leaves the pad high-Z.
  if (OUT_REG) begin : g_out_reg
    logic i_top_q, i_top_d;
    logic t_top_q, t_top_d;

    always_comb begin
      i_top_d = I;
      t_top_d = ~T;
    end

    always_ff @(posedge UserCLK or posedge RST) begin
      if (RST) begin
        i_top_q <= 1'b0;
        t_top_q <= 1'b0;
      end else begin
        i_top_q <= i_top_d;
        t_top_q <= t_top_d;
      end
    end

    assign I_top = i_top_q;
    assign T_top = t_top_q;
  end else begin : g_out_comb
    assign I_top = I;
    assign T_top = ~T;
  end

endmodule

// File: tb/tb_io_1_bidirectional_sync_filter.sv
// Directed bench for the pad conditioning stage: three configurations share
// one stimulus set (defaults, fast filter with deep sync, unregistered drive).
module tb_io_1_bidirectional_sync_filter;

  logic clk;
  logic rst;
  logic i_in;
  logic t_in;
  logic o_top;

  logic a_i_top, a_t_top, a_o, a_q, a_rise, a_fall;
  logic b_i_top, b_t_top, b_o, b_q, b_rise, b_fall;
  logic c_i_top, c_t_top, c_o, c_q, c_rise, c_fall;

  int checks = 0;
  int errors = 0;

  io_1_bidirectional_sync_filter #(
    .SYNC_STAGES(2), .FILTER_LEN(4), .OUT_REG(1'b1)
  ) u_a (
    .UserCLK(clk), .RST(rst), .I(i_in), .T(t_in), .O_top(o_top),
    .I_top(a_i_top), .T_top(a_t_top), .O(a_o), .Q(a_q),
    .RISE(a_rise), .FALL(a_fall)
  );

  io_1_bidirectional_sync_filter #(
    .SYNC_STAGES(3), .FILTER_LEN(1), .OUT_REG(1'b1)
  ) u_b (
    .UserCLK(clk), .RST(rst), .I(i_in), .T(t_in), .O_top(o_top),
    .I_top(b_i_top), .T_top(b_t_top), .O(b_o), .Q(b_q),
    .RISE(b_rise), .FALL(b_fall)
  );

  io_1_bidirectional_sync_filter #(
    .SYNC_STAGES(2), .FILTER_LEN(4), .OUT_REG(1'b0)
  ) u_c (
    .UserCLK(clk), .RST(rst), .I(i_in), .T(t_in), .O_top(o_top),
    .I_top(c_i_top), .T_top(c_t_top), .O(c_o), .Q(c_q),
    .RISE(c_rise), .FALL(c_fall)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_q, exp_o, exp_r;
    rst = 1'b1; o_top = 1'b1; i_in = 1'b1; t_in = 1'b0;
    tick(); tick();
    checks++; if (a_o !== 1'b0)     begin errors++; $display("FAIL reset_o: got %b want 0", a_o); end
    checks++; if (a_q !== 1'b0)     begin errors++; $display("FAIL reset_q: got %b want 0", a_q); end
    checks++; if (a_rise !== 1'b0)  begin errors++; $display("FAIL reset_rise: got %b want 0", a_rise); end
    checks++; if (a_fall !== 1'b0)  begin errors++; $display("FAIL reset_fall: got %b want 0", a_fall); end
    checks++; if (a_i_top !== 1'b0) begin errors++; $display("FAIL reset_i_top: got %b want 0", a_i_top); end
    checks++; if (a_t_top !== 1'b0) begin errors++; $display("FAIL reset_t_top: got %b want 0", a_t_top); end
    checks++; if (b_o !== 1'b0 || b_q !== 1'b0) begin errors++; $display("FAIL reset_b_oq: got %b%b want 00", b_o, b_q); end
    checks++; if (c_i_top !== 1'b1 || c_t_top !== 1'b1) begin errors++; $display("FAIL reset_comb_drive: got %b%b want 11", c_i_top, c_t_top); end
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_q = (n >= 2);
      exp_o = (n >= 6);
      exp_r = (n == 6);
      checks++; if (a_q !== exp_q)    begin errors++; $display("FAIL release_q c%0d: got %b want %b", n, a_q, exp_q); end
      checks++; if (a_o !== exp_o)    begin errors++; $display("FAIL release_o c%0d: got %b want %b", n, a_o, exp_o); end
      checks++; if (a_rise !== exp_r) begin errors++; $display("FAIL release_rise c%0d: got %b want %b", n, a_rise, exp_r); end
      checks++; if (a_fall !== 1'b0)  begin errors++; $display("FAIL release_fall c%0d: got %b want 0", n, a_fall); end
    end
  endtask

  task automatic test_clean_edge();
    logic exp_q, exp_o, exp_s;
    o_top = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_q = (n < 2);
      exp_o = (n < 6);
      exp_s = (n == 6);
      checks++; if (a_q !== exp_q)    begin errors++; $display("FAIL fall_edge_q c%0d: got %b want %b", n, a_q, exp_q); end
      checks++; if (a_o !== exp_o)    begin errors++; $display("FAIL fall_edge_o c%0d: got %b want %b", n, a_o, exp_o); end
      checks++; if (a_fall !== exp_s) begin errors++; $display("FAIL fall_edge_fall c%0d: got %b want %b", n, a_fall, exp_s); end
      checks++; if (a_rise !== 1'b0)  begin errors++; $display("FAIL fall_edge_rise c%0d: got %b want 0", n, a_rise); end
    end
    o_top = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      exp_q = (n >= 2);
      exp_o = (n >= 6);
      exp_s = (n == 6);
      checks++; if (a_q !== exp_q)    begin errors++; $display("FAIL rise_edge_q c%0d: got %b want %b", n, a_q, exp_q); end
      checks++; if (a_o !== exp_o)    begin errors++; $display("FAIL rise_edge_o c%0d: got %b want %b", n, a_o, exp_o); end
      checks++; if (a_rise !== exp_s) begin errors++; $display("FAIL rise_edge_rise c%0d: got %b want %b", n, a_rise, exp_s); end
      checks++; if (a_fall !== 1'b0)  begin errors++; $display("FAIL rise_edge_fall c%0d: got %b want 0", n, a_fall); end
    end
  endtask

  task automatic test_glitch();
    logic exp_q, exp_o, exp_r, exp_f;
    for (int pw = 3; pw <= 4; pw++) begin
      o_top = 1'b0;
      repeat (10) tick();
      o_top = 1'b1;
      for (int n = 1; n <= 16; n++) begin
        tick();
        exp_q = (n >= 2) && (n < 2 + pw);
        exp_o = (pw >= 4) && (n >= 6) && (n < 6 + pw);
        exp_r = (pw >= 4) && (n == 6);
        exp_f = (pw >= 4) && (n == 6 + pw);
        checks++; if (a_q !== exp_q)    begin errors++; $display("FAIL glitch%0d_q c%0d: got %b want %b", pw, n, a_q, exp_q); end
        checks++; if (a_o !== exp_o)    begin errors++; $display("FAIL glitch%0d_o c%0d: got %b want %b", pw, n, a_o, exp_o); end
        checks++; if (a_rise !== exp_r) begin errors++; $display("FAIL glitch%0d_rise c%0d: got %b want %b", pw, n, a_rise, exp_r); end
        checks++; if (a_fall !== exp_f) begin errors++; $display("FAIL glitch%0d_fall c%0d: got %b want %b", pw, n, a_fall, exp_f); end
        o_top = (n < pw);
      end
    end
  endtask

  task automatic test_square();
    logic drv [20];
    logic exp_o, prev_o, exp_r, exp_f;
    o_top = 1'b0;
    repeat (8) tick();
    prev_o = 1'b0;
    for (int n = 0; n < 20; n++) begin
      exp_o = (n >= 4) ? drv[n-4] : 1'b0;
      exp_r = exp_o & ~prev_o;
      exp_f = ~exp_o & prev_o;
      checks++; if (b_o !== exp_o)    begin errors++; $display("FAIL square_o c%0d: got %b want %b", n, b_o, exp_o); end
      checks++; if (b_rise !== exp_r) begin errors++; $display("FAIL square_rise c%0d: got %b want %b", n, b_rise, exp_r); end
      checks++; if (b_fall !== exp_f) begin errors++; $display("FAIL square_fall c%0d: got %b want %b", n, b_fall, exp_f); end
      checks++; if (b_rise === 1'b1 && b_fall === 1'b1) begin errors++; $display("FAIL square_both c%0d: got 11 want not both", n); end
      prev_o = exp_o;
      drv[n] = (n < 12) ? ~n[0] : 1'b0;
      o_top = drv[n];
      tick();
    end
  endtask

  task automatic test_drive();
    t_in = 1'b1; i_in = 1'b0;
    tick(); tick();
    t_in = 1'b0; i_in = 1'b1;
    #1;
    checks++; if (c_t_top !== 1'b1 || c_i_top !== 1'b1) begin errors++; $display("FAIL drive_comb_on: got %b%b want 11", c_t_top, c_i_top); end
    checks++; if (a_t_top !== 1'b0 || a_i_top !== 1'b0) begin errors++; $display("FAIL drive_reg_hold_off: got %b%b want 00", a_t_top, a_i_top); end
    tick();
    checks++; if (a_t_top !== 1'b1 || a_i_top !== 1'b1) begin errors++; $display("FAIL drive_reg_on: got %b%b want 11", a_t_top, a_i_top); end
    t_in = 1'b1; i_in = 1'b0;
    #1;
    checks++; if (c_t_top !== 1'b0 || c_i_top !== 1'b0) begin errors++; $display("FAIL drive_comb_off: got %b%b want 00", c_t_top, c_i_top); end
    checks++; if (a_t_top !== 1'b1 || a_i_top !== 1'b1) begin errors++; $display("FAIL drive_reg_hold_on: got %b%b want 11", a_t_top, a_i_top); end
    tick();
    checks++; if (a_t_top !== 1'b0 || a_i_top !== 1'b0) begin errors++; $display("FAIL drive_reg_off: got %b%b want 00", a_t_top, a_i_top); end
  endtask

  task automatic test_reset_mid();
    logic exp_o, exp_r;
    int rises;
    o_top = 1'b0;
    repeat (10) tick();
    o_top = 1'b1;
    repeat (4) tick();
    checks++; if (a_q !== 1'b1 || a_o !== 1'b0) begin errors++; $display("FAIL mid_pending: got q%b o%b want q1 o0", a_q, a_o); end
    rst = 1'b1;
    #1;
    checks++; if (a_q !== 1'b0 || a_o !== 1'b0) begin errors++; $display("FAIL mid_async_clear: got q%b o%b want q0 o0", a_q, a_o); end
    tick();
    rst = 1'b0;
    rises = 0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp_o = (n >= 6);
      exp_r = (n == 6);
      if (a_rise === 1'b1) rises++;
      checks++; if (a_o !== exp_o)    begin errors++; $display("FAIL mid_o c%0d: got %b want %b", n, a_o, exp_o); end
      checks++; if (a_rise !== exp_r) begin errors++; $display("FAIL mid_rise c%0d: got %b want %b", n, a_rise, exp_r); end
    end
    checks++; if (rises != 1) begin errors++; $display("FAIL mid_rise_count: got %0d want 1", rises); end
  endtask

  initial begin
    rst = 1'b1; i_in = 1'b0; t_in = 1'b1; o_top = 1'b0;
    test_reset();
    test_clean_edge();
    test_glitch();
    test_square();
    test_drive();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_1_bidirectional_sync_filter.md
Name: io_1_bidirectional_sync_filter

Overview:
Pad-side conditioning stage placed between the external pin and the fabric-facing bidirectional IO BEL in the W_IO tile. It synchronises the asynchronous pad input O_top into the UserCLK domain, removes glitches with a stability counter and produces rise/fall strobes. It also registers the fabric's I/T drive toward the pad so pad timing is launched from a flop. I_top/T_top keep the existing convention: T_top is active-high output-enable, the inverse of fabric T.

Parameters:
SYNC_STAGES, 2, synchroniser flop count on O_top; legal range 2..4.
FILTER_LEN, 4, consecutive identical synchronised samples required before O changes; legal range 1..16.
OUT_REG, 1, 1 = I_top/T_top registered; 0 = combinational pass-through.

Ports:
UserCLK  input  1  fabric user clock, sole clock; EXTERNAL, SHARED_PORT.
RST  input  1  asynchronous active-high reset.
I  input  1  fabric data to drive onto pad.
T  input  1  fabric tristate control; 1 = high-Z.
O_top  input  1  raw pad level, asynchronous (EXTERNAL).
I_top  output  1  pad drive data (EXTERNAL).
T_top  output  1  pad output-enable, active high, = ~T (EXTERNAL).
O  output  1  synchronised, glitch-filtered pad level.
Q  output  1  synchronised, unfiltered pad level (last sync stage).
RISE  output  1  one-cycle strobe on O 0->1.
FALL  output  1  one-cycle strobe on O 1->0.

Behaviour:
- Clock and reset: all flops on posedge UserCLK; RST clears asynchronously; release is synchronous to the next edge.
- Reset values: sync chain 0, Q=0, O=0, RISE=0, FALL=0, filter counter 0; with OUT_REG=1, I_top=0 and T_top=0 (pad released and high-Z).
- Synchroniser: shift chain of SYNC_STAGES flops; Q = last stage. Pad edge -> Q is SYNC_STAGES cycles, plus metastability uncertainty of +1.
- Filter: counter cnt, width clog2(FILTER_LEN)+1.
  - If Q == O: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: O <= Q and cnt <= 0.
  - Else: cnt <= cnt+1.
- Filter latency: O changes FILTER_LEN cycles after Q first differs, provided Q stays constant.
- FILTER_LEN=1: O follows Q with exactly 1 cycle delay. Total pad->O latency = SYNC_STAGES + FILTER_LEN cycles.
- Glitch rejection: a Q excursion shorter than FILTER_LEN cycles returns Q == O, clears cnt and never reaches O.
- Counter saturation: cnt never exceeds FILTER_LEN-1; no wrap is possible.
- Strobes: RISE/FALL are registered, high in the same cycle O first shows the new value, for exactly 1 cycle. Never both high in one cycle.
- Toggle case: if Q toggles every cycle, O holds indefinitely and RISE/FALL stay 0.
- Drive path, OUT_REG=1: I_top <= I and T_top <= ~T, 1-cycle latency, no dependency on the receive path.
- Drive path, OUT_REG=0: I_top = I and T_top = ~T combinationally. Reset then has no effect on I_top/T_top.
- Reset mid-operation: asserting RST during a pending filter count discards the count. O returns to 0 even if the pad is high. After release, a high pad re-qualifies through the full SYNC_STAGES + FILTER_LEN latency and produces a RISE.
- Loopback: while T_top=1 the pad echo of I_top is treated as ordinary input; there is no suppression.

Decomposition:
- Shared package io_pkg holds:
  - default constants IO_SYNC_STAGES_DEF=2, IO_FILTER_LEN_DEF=4;
  - the legal-range bounds, checked by elaboration-time assertions in the top module.
- Natural sub-module: io_glitch_filter (parameter FILTER_LEN; ports UserCLK, RST, d -> q, rise, fall). The top instantiates it after the inline sync chain.
- The drive path stays inline.

Test Plan:
- Reset: RST=1 with O_top=1, I=1, T=0 -> O=0, Q=0, RISE=0, FALL=0, I_top=0, T_top=0. After RST=0 (defaults) -> Q=1 after 2 cycles, O=1 with a single RISE pulse 6 cycles after release.
- Clean edge, defaults: O_top 0->1 at cycle 0 -> Q=1 at cycle 2, O=1 and RISE=1 at cycle 6 only. O_top 1->0 later -> FALL after the same 6 cycles.
- Glitch: O_top high for 3 cycles then low -> Q pulses for 3 cycles, O stays 0, RISE never asserts. A 4-cycle pulse -> O pulses 1 for 4 cycles, one RISE and one FALL.
- FILTER_LEN=1, SYNC_STAGES=3: square wave O_top with period 2 -> O toggles every cycle, delayed 4 cycles; RISE/FALL alternate, never coincident.
- Drive path, OUT_REG=1: T=1->0 and I=1 at cycle 0 -> T_top=1, I_top=1 at cycle 1. Repeat with OUT_REG=0 -> same cycle, combinational.
- Reset mid-filter: O_top rises, RST pulsed 1 cycle when cnt=2 -> O=0 held. O rises 6 cycles after RST release, with exactly one RISE.
